// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - mode/state encodings and fixed-point angle constants for the CORDIC core
package cordic_pkg;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREROT = 2'd1,
    ST_ITER   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Master tables are held at 30 fractional bits and rounded down to the datapath scale.
  localparam int TAB_FRAC   = 30;
  localparam int FRAC_W_DEF = 20;

  function automatic longint scale_q(input longint v30, input int frac_w);
    return (v30 + (longint'(1) << (TAB_FRAC - 1 - frac_w))) >>> (TAB_FRAC - frac_w);
  endfunction

  function automatic longint atan_q(input int i, input int frac_w);
    longint t;
    case (i)
      0:       t = 64'sd843314856;
      1:       t = 64'sd497837829;
      2:       t = 64'sd263043836;
      3:       t = 64'sd133525158;
      4:       t = 64'sd67021686;
      5:       t = 64'sd33543515;
      6:       t = 64'sd16775850;
      7:       t = 64'sd8388437;
      8:       t = 64'sd4194282;
      9:       t = 64'sd2097149;
      // beyond i=9 atan(2^-i) is 2^-i minus less than one 2^-30 LSB
      default: t = (i <= TAB_FRAC) ? ((longint'(1) << (TAB_FRAC - i)) - 64'sd1) : 64'sd0;
    endcase
    return scale_q(t, frac_w);
  endfunction

  function automatic longint half_pi_q(input int frac_w);
    return scale_q(64'sd1686629713, frac_w);
  endfunction

  function automatic longint k_inv_q(input int frac_w);
    return scale_q(64'sd652032874, frac_w);
  endfunction

  localparam longint HALF_PI = half_pi_q(FRAC_W_DEF);
  localparam longint K_INV   = k_inv_q(FRAC_W_DEF);

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational atan(2^-i) table indexed by the iteration counter
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int FRAC_W = 20,
  parameter int ITER   = 16,
  parameter int CNT_W  = 5
) (
  input  logic [CNT_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_atan
);

  // Sized to the full counter range so every index value is a legal address.
  logic [DATA_W-1:0] w_rom [2**CNT_W];

  for (genvar g = 0; g < 2**CNT_W; g++) begin : g_rom
    if (g < ITER) begin : g_used
      assign w_rom[g] = DATA_W'(atan_q(g, FRAC_W));
    end else begin : g_unused
      assign w_rom[g] = '0;
    end
  end

  assign o_atan = w_rom[i_idx];

endmodule

// File: rtl/cordic_iter_core.sv
// rtl/cordic_iter_core.sv - iterative rotation/vectoring CORDIC, one micro-rotation per clock
module cordic_iter_core
  import cordic_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int FRAC_W = 20,
  parameter int ITER   = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic [DATA_W-1:0] out_z,
  output logic              busy
);

  localparam logic signed [DATA_W-1:0] HALF_PI_Q = DATA_W'(half_pi_q(FRAC_W));
  localparam logic [CNT_W-1:0]         LAST_I    = CNT_W'(ITER - 1);

  state_t                    r_state;
  logic                      r_mode;
  logic signed [DATA_W-1:0]  r_x;
  logic signed [DATA_W-1:0]  r_y;
  logic signed [DATA_W-1:0]  r_z;
  logic        [CNT_W-1:0]   r_i;

  logic signed [DATA_W-1:0]  w_atan;
  logic signed [DATA_W-1:0]  w_xs;
  logic signed [DATA_W-1:0]  w_ys;
  logic signed [DATA_W-1:0]  w_x_nxt;
  logic signed [DATA_W-1:0]  w_y_nxt;
  logic signed [DATA_W-1:0]  w_z_nxt;
  logic                      w_d_pos;

  cordic_atan_rom #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ITER   (ITER),
    .CNT_W  (CNT_W)
  ) u_atan_rom (
    .i_idx  (r_i),
    .o_atan (w_atan)
  );

  assign in_ready = (r_state == ST_IDLE) & ~rst;
  assign busy     = (r_state != ST_IDLE);

  // Rotation drives z toward zero, vectoring drives y toward zero.
  assign w_d_pos = (r_mode == MODE_ROT) ? ~r_z[DATA_W-1] : r_y[DATA_W-1];
  assign w_xs    = r_x >>> r_i;
  assign w_ys    = r_y >>> r_i;
  assign w_x_nxt = w_d_pos ? (r_x - w_ys)   : (r_x + w_ys);
  assign w_y_nxt = w_d_pos ? (r_y + w_xs)   : (r_y - w_xs);
  assign w_z_nxt = w_d_pos ? (r_z - w_atan) : (r_z + w_atan);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_ROT;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_i       <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mode  <= in_mode;
            r_x     <= in_x;
            r_y     <= in_y;
            r_z     <= in_z;
            r_i     <= '0;
            r_state <= ST_PREROT;
          end
        end
        ST_PREROT: begin
          // Fold by +/-90 degrees so the iterations only ever see the right half-plane.
          if (r_mode == MODE_ROT) begin
            if (r_z > HALF_PI_Q) begin
              r_x <= -r_y;
              r_y <= r_x;
              r_z <= r_z - HALF_PI_Q;
            end else if (r_z < -HALF_PI_Q) begin
              r_x <= r_y;
              r_y <= -r_x;
              r_z <= r_z + HALF_PI_Q;
            end
          end else if (r_x[DATA_W-1]) begin
            if (!r_y[DATA_W-1]) begin
              r_x <= r_y;
              r_y <= -r_x;
              r_z <= r_z + HALF_PI_Q;
            end else begin
              r_x <= -r_y;
              r_y <= r_x;
              r_z <= r_z - HALF_PI_Q;
            end
          end
          r_state <= ST_ITER;
        end
        ST_ITER: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          r_i <= r_i + 1'b1;
          if (r_i == LAST_I) begin
            r_state   <= ST_DONE;
            out_valid <= 1'b1;
            out_x     <= w_x_nxt;
            out_y     <= w_y_nxt;
            out_z     <= w_z_nxt;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_core.sv
// tb/tb_cordic_iter_core.sv - directed scoreboard bench for cordic_iter_core
module tb_cordic_iter_core;
  import cordic_pkg::*;

  localparam int DATA_W = 24;
  localparam int FRAC_W = 20;
  localparam int ITER   = 16;
  localparam int CNT_W  = 5;
  // The last micro-rotation leaves up to atan(2^-(ITER-1)) of residual angle.
  localparam int TOL    = 2 * ITER;
  localparam int KI     = int'(K_INV);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_mode = 1'b0;
  logic [DATA_W-1:0] in_x = '0;
  logic [DATA_W-1:0] in_y = '0;
  logic [DATA_W-1:0] in_z = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_x;
  logic [DATA_W-1:0] out_y;
  logic [DATA_W-1:0] out_z;
  logic              busy;

  cordic_iter_core #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ITER   (ITER),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int z;
    bit chk_z;
    bit exact;
    int acc;
    int id;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   next_id = 0;

  function automatic int sx(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic bit near(input int obs, input int expv, input bit exact);
    int d;
    d = obs - expv;
    if (d < 0) d = -d;
    return exact ? (d == 0) : (d <= TOL);
  endfunction

  task automatic check(input string tag, input int obs, input int expv, input bit ok);
    tests++;
    assert (ok === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic send(input bit m, input int x, input int y, input int z,
                      input int ex, input int ey, input int ez,
                      input bit cz, input bit exact, input bit push, output int acc);
    int   n;
    exp_t e;
    in_mode  = m;
    in_x     = x[DATA_W-1:0];
    in_y     = y[DATA_W-1:0];
    in_z     = z[DATA_W-1:0];
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept#%0d", next_id), n, 0, in_ready === 1'b1);
    acc = cyc;
    if (push) begin
      e.x = ex; e.y = ey; e.z = ez; e.chk_z = cz; e.exact = exact;
      e.acc = acc; e.id = next_id;
      sb_q.push_back(e);
    end
    next_id++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n, 300, n < 300);
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          check("sb_nonempty", sb_q.size(), 1, sb_q.size() > 0);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("latency#%0d", e.id), cyc - e.acc, ITER + 2, (cyc - e.acc) == ITER + 2);
            check($sformatf("out_x#%0d", e.id), sx(out_x), e.x, near(sx(out_x), e.x, e.exact));
            check($sformatf("out_y#%0d", e.id), sx(out_y), e.y, near(sx(out_y), e.y, e.exact));
            if (e.chk_z)
              check($sformatf("out_z#%0d", e.id), sx(out_z), e.z, near(sx(out_z), e.z, e.exact));
          end
        end
        prev = out_valid;
      end
    end
  end

  initial begin : stim
    int a1, a2, n, seen;
    logic [DATA_W-1:0] ox, oy, oz;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0, in_ready === 1'b0);
    check("rst_out_valid", out_valid, 0, out_valid === 1'b0);
    check("rst_busy", busy, 0, busy === 1'b0);
    check("rst_out_x", sx(out_x), 0, out_x === '0);
    check("rst_out_z", sx(out_z), 0, out_z === '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1, in_ready === 1'b1);

    send(MODE_ROT, KI, 0, 0, 1048576, 0, 0, 1, 0, 1, a1);
    check("busy_running", busy, 1, busy === 1'b1);
    check("no_ready_running", in_ready, 0, in_ready === 1'b0);
    wait_idle();
    send(MODE_ROT, KI, 0, 823550, 741455, 741455, 0, 1, 0, 1, a1);
    wait_idle();
    send(MODE_ROT, KI, 0, -823550, 741455, -741455, 0, 1, 0, 1, a1);
    wait_idle();
    send(MODE_ROT, KI, 0, 3294199, -1048576, 0, 0, 1, 0, 1, a1);
    wait_idle();
    send(MODE_ROT, KI, 0, -3294199, -1048576, 0, 0, 1, 0, 1, a1);
    wait_idle();
    send(MODE_VEC, 314573, 419430, 0, 863377, 0, 972335, 1, 0, 1, a1);
    wait_idle();
    send(MODE_VEC, -314573, 419430, 0, 863377, 0, 2321864, 1, 0, 1, a1);
    wait_idle();
    send(MODE_VEC, -314573, -419430, 0, 863377, 0, -2321864, 1, 0, 1, a1);
    wait_idle();
    send(MODE_VEC, 0, 0, 0, 0, 0, 0, 0, 1, 1, a1);
    wait_idle();

    // back-to-back throughput with the consumer always ready
    send(MODE_ROT, KI, 0, 0, 1048576, 0, 0, 1, 0, 1, a1);
    send(MODE_ROT, KI, 0, 823550, 741455, 741455, 0, 1, 0, 1, a2);
    check("throughput", a2 - a1, ITER + 3, (a2 - a1) == ITER + 3);
    wait_idle();

    // consumer stall: result must hold and new operands must be refused
    out_ready = 1'b0;
    send(MODE_ROT, KI, 0, 823550, 741455, 741455, 0, 1, 0, 1, a1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_wait", n, 100, out_valid === 1'b1);
    ox = out_x; oy = out_y; oz = out_z;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      in_mode  = MODE_ROT;
      in_x     = 24'h012345;
      in_y     = 24'h000000;
      in_z     = 24'h054321;
      @(negedge clk);
      check("stall_valid", out_valid, 1, out_valid === 1'b1);
      check("stall_in_ready", in_ready, 0, in_ready === 1'b0);
      check("stall_x", sx(out_x), sx(ox), out_x === ox);
      check("stall_y", sx(out_y), sx(oy), out_y === oy);
      check("stall_z", sx(out_z), sx(oz), out_z === oz);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", out_valid, 0, out_valid === 1'b0);
    check("release_busy", busy, 0, busy === 1'b0);
    repeat (25) @(negedge clk);
    check("stall_pulses_ignored", busy, 0, busy === 1'b0);

    // reset during iteration 7, with in_valid asserted alongside rst
    send(MODE_ROT, KI, 0, 823550, 0, 0, 0, 0, 0, 0, a1);
    repeat (8) @(negedge clk);
    check("abort_busy_pre", busy, 1, busy === 1'b1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_mode  = MODE_ROT;
    in_x     = KI[DATA_W-1:0];
    in_y     = '0;
    in_z     = '0;
    @(negedge clk);
    check("abort_in_ready_rst", in_ready, 0, in_ready === 1'b0);
    check("abort_busy_rst", busy, 0, busy === 1'b0);
    check("abort_valid_rst", out_valid, 0, out_valid === 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_in_ready_after", in_ready, 1, in_ready === 1'b1);
    check("abort_busy_after", busy, 0, busy === 1'b0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 0, seen == 0);
    send(MODE_ROT, KI, 0, 823550, 741455, 741455, 0, 1, 0, 1, a1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
